// File: rtl/vedic_pkg.sv
// Shared types and sizing helpers for the iterative Vedic multiplier controller.
// Contents:
//   state_t  - controller states IDLE / BUSY / DONE
//   digits() - number of 2-bit digits per operand for a given width
//   cnt_w()  - bit width of a digit counter for a given width
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of 2-bit digits in a w-bit operand.
    function automatic int unsigned digits(input int unsigned w);
        return w / 2;
    endfunction

    // Digit counter width; at least one bit so the counter always exists.
    function automatic int unsigned cnt_w(input int unsigned w);
        return ((w / 2) > 1) ? $clog2(w / 2) : 1;
    endfunction

endpackage

// File: rtl/vedic_pp2x2.sv
// Combinational 2x2 Vedic (Urdhva-Tiryagbhyam) multiplier cell.
// Ports:
//   a [1:0] - multiplicand digit
//   b [1:0] - multiplier digit
//   p [3:0] - product a*b
module vedic_pp2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic s1;
    logic c1;
    logic s2;
    logic c2;

    // Cross terms are half-added; their carry joins the high vertical term.
    assign s1 = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1 = (a[1] & b[0]) & (a[0] & b[1]);
    assign s2 = (a[1] & b[1]) ^ c1;
    assign c2 = (a[1] & b[1]) & c1;

    assign p = {c2, s2, s1, a[0] & b[0]};

endmodule

// File: rtl/vedic_iter_mult_ctrl.sv
// Iterative WIDTH x WIDTH unsigned multiplier built around a single 2x2 Vedic cell.
// One digit pair is multiplied per cycle, shifted into place and accumulated.
// Optional feature: define VEDIC_ZERO_SKIP_EN to bypass BUSY when either operand is zero.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (in_a, in_b)
//   out_valid/out_ready - product handshake (out_p = in_a * in_b)
//   busy                - high while the digit loop runs
module vedic_iter_mult_ctrl
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int unsigned D    = digits(WIDTH);
    localparam int unsigned CW   = cnt_w(WIDTH);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned SW   = $clog2(PW);
    localparam int unsigned SUMW = SW - 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    state_t          state_q;
    state_t          state_n;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_n;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_n;
    logic [CW-1:0]   i_q;
    logic [CW-1:0]   i_n;
    logic [CW-1:0]   j_q;
    logic [CW-1:0]   j_n;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [1:0]      a_dig_c;
    logic [1:0]      b_dig_c;
    logic [3:0]      pp_c;
    logic [SW-1:0]   shamt_c;
    logic [PW-1:0]   addend_c;
    logic            accept_c;

    // Current digit pair and its weight 2*(i+j).
    assign a_dig_c  = 2'(a_q >> {i_q, 1'b0});
    assign b_dig_c  = 2'(b_q >> {j_q, 1'b0});
    assign shamt_c  = {SUMW'(i_q) + SUMW'(j_q), 1'b0};
    assign addend_c = PW'(pp_c) << shamt_c;
    assign accept_c = in_valid & in_ready_q;

    vedic_pp2x2 u_pp (
        .a (a_dig_c),
        .b (b_dig_c),
        .p (pp_c)
    );

    // State and datapath registers; handshake outputs are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            a_q         <= a_n;
            b_q         <= b_n;
            acc_q       <= acc_n;
            i_q         <= i_n;
            j_q         <= j_n;
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
            busy_q      <= (state_n == BUSY);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        acc_n   = acc_q;
        i_n     = i_q;
        j_n     = j_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_n     = in_a;
                    b_n     = in_b;
                    acc_n   = '0;
                    i_n     = '0;
                    j_n     = '0;
                    state_n = BUSY;
`ifdef VEDIC_ZERO_SKIP_EN
                    if ((in_a == '0) || (in_b == '0)) begin
                        state_n = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                acc_n = acc_q + addend_c;
                // i is the fast index; j steps when i wraps.
                if (i_q == LAST) begin
                    i_n = '0;
                    if (j_q == LAST) begin
                        j_n     = '0;
                        state_n = DONE;
                    end else begin
                        j_n = j_q + CW'(1);
                    end
                end else begin
                    i_n = i_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_p     = acc_q;

endmodule
